// File: rtl/pmem_arb_pkg.sv
// Shared types and sizes for the physical-memory arbiter.
//
// Contents:
//   LINE_W, BEAT_W, BEATS : cacheline width, memory beat width, beats per line
//   arb_state_t           : arbiter FSM states
//   requester_t           : identity of the client that owns the current burst
package pmem_arb_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_D,
        REQ_I,
        REQ_PF
    } requester_t;

endpackage

// File: rtl/line_burst_buffer.sv
// Line register and beat sequencing for one cacheline burst.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clear           : start of a new burst, beat counter back to 0
//   load_wdata      : capture wdata_in as the line to be written out
//   wdata_in        : writeback line from the dcache
//   rd_beat         : a read beat is being returned on mem_rdata this cycle
//   wr_beat         : the current write beat is being accepted this cycle
//   mem_rdata       : read beat from memory
//   line            : assembled read line (stable between read bursts)
//   wr_beat_data    : write-line slice selected by the beat counter
//   last_beat       : beat counter is on the final beat of the line
module line_burst_buffer #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load_wdata,
    input  logic [BEATS*BEAT_W-1:0]   wdata_in,
    input  logic                      rd_beat,
    input  logic                      wr_beat,
    input  logic [BEAT_W-1:0]         mem_rdata,
    output logic [BEATS*BEAT_W-1:0]   line,
    output logic [BEAT_W-1:0]         wr_beat_data,
    output logic                      last_beat
);

    localparam int KW = $clog2(BEATS);

    logic [BEATS*BEAT_W-1:0] line_q;
    logic [BEATS*BEAT_W-1:0] wdata_q;
    logic [KW-1:0]           beat_cnt;

    // The write line is kept separate from the read line so that a writeback
    // never disturbs the last line handed back to a reader.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q   <= '0;
            wdata_q  <= '0;
            beat_cnt <= '0;
        end else begin
            if (clear) begin
                beat_cnt <= '0;
            end else if (rd_beat || wr_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (load_wdata) begin
                wdata_q <= wdata_in;
            end
            if (rd_beat) begin
                line_q[int'(beat_cnt)*BEAT_W +: BEAT_W] <= mem_rdata;
            end
        end
    end

    assign line         = line_q;
    assign wr_beat_data = wdata_q[int'(beat_cnt)*BEAT_W +: BEAT_W];
    assign last_beat    = (beat_cnt == KW'(BEATS - 1));

endmodule

// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter and burst adaptor for the icache (demand and
// prefetch) and the dcache. Whole-line requests are serialised onto one
// 64-bit, 4-beat burst memory port; the assembled line and a one-cycle
// completion pulse go back to the requester that won arbitration.
//
// Build option: PMEM_PREFETCH_EN -- when defined the icache prefetch port
// takes part in arbitration at lowest priority; otherwise pf_req/pf_address
// are ignored and pf_ready stays 0.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   i_pmem_read/address            : icache demand line read
//   i_pmem_rdata/resp              : line and completion pulse to icache
//   pf_req/pf_address, pf_ready    : icache prefetch request and completion
//   d_pmem_read/write/address/wdata: dcache line read or writeback
//   d_pmem_rdata/resp              : line and completion pulse to dcache
//   mem_read/write/address/wdata   : burst memory request side
//   mem_rdata/resp                 : burst memory beat return/accept
module pmem_arbiter #(
    parameter int BEATS  = pmem_arb_pkg::BEATS,
    parameter int BEAT_W = pmem_arb_pkg::BEAT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_pmem_read,
    input  logic [31:0]             i_pmem_address,
    output logic [BEATS*BEAT_W-1:0] i_pmem_rdata,
    output logic                    i_pmem_resp,
    input  logic                    pf_req,
    input  logic [31:0]             pf_address,
    output logic                    pf_ready,
    input  logic                    d_pmem_read,
    input  logic                    d_pmem_write,
    input  logic [31:0]             d_pmem_address,
    input  logic [BEATS*BEAT_W-1:0] d_pmem_wdata,
    output logic [BEATS*BEAT_W-1:0] d_pmem_rdata,
    output logic                    d_pmem_resp,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [31:0]             mem_address,
    output logic [BEAT_W-1:0]       mem_wdata,
    input  logic [BEAT_W-1:0]       mem_rdata,
    input  logic                    mem_resp
);

    import pmem_arb_pkg::*;

    arb_state_t              state;
    arb_state_t              next_state;
    requester_t              owner;
    requester_t              grant_id;
    logic [31:0]             addr_q;
    logic [31:0]             grant_addr;
    logic                    grant;
    logic                    grant_write;
    logic [BEATS*BEAT_W-1:0] line;
    logic [BEAT_W-1:0]       wr_beat_data;
    logic                    last_beat;
    logic                    unused_ok;

    // Requests are only looked at in IDLE; DONE deliberately ignores them so
    // the requester that was just answered has a cycle to drop its request.
    // A simultaneous dcache read and write resolves to the write.
    always_comb begin
        next_state  = state;
        grant       = 1'b0;
        grant_write = 1'b0;
        grant_id    = REQ_NONE;
        grant_addr  = '0;
        case (state)
            IDLE: begin
                if (d_pmem_write) begin
                    grant       = 1'b1;
                    grant_write = 1'b1;
                    grant_id    = REQ_D;
                    grant_addr  = {d_pmem_address[31:5], 5'b0};
                    next_state  = WR_BURST;
                end else if (d_pmem_read) begin
                    grant      = 1'b1;
                    grant_id   = REQ_D;
                    grant_addr = {d_pmem_address[31:5], 5'b0};
                    next_state = RD_BURST;
                end else if (i_pmem_read) begin
                    grant      = 1'b1;
                    grant_id   = REQ_I;
                    grant_addr = {i_pmem_address[31:5], 5'b0};
                    next_state = RD_BURST;
`ifdef PMEM_PREFETCH_EN
                end else if (pf_req) begin
                    grant      = 1'b1;
                    grant_id   = REQ_PF;
                    grant_addr = {pf_address[31:5], 5'b0};
                    next_state = RD_BURST;
`endif
                end
            end
            RD_BURST, WR_BURST: begin
                // Leaving on the last beat keeps the 2-bit counter from
                // ever starting a fifth beat.
                if (mem_resp && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Owner and burst address are held for the whole transaction so the
    // response in DONE goes to whoever won, whatever the inputs do meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  <= REQ_NONE;
            addr_q <= '0;
        end else if (grant) begin
            owner  <= grant_id;
            addr_q <= grant_addr;
        end
    end

    line_burst_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .clear        (grant),
        .load_wdata   (grant && grant_write),
        .wdata_in     (d_pmem_wdata),
        .rd_beat      (mem_read && mem_resp),
        .wr_beat      (mem_write && mem_resp),
        .mem_rdata    (mem_rdata),
        .line         (line),
        .wr_beat_data (wr_beat_data),
        .last_beat    (last_beat)
    );

    assign mem_read     = (state == RD_BURST);
    assign mem_write    = (state == WR_BURST);
    assign mem_address  = addr_q;
    assign mem_wdata    = mem_write ? wr_beat_data : '0;
    assign i_pmem_rdata = line;
    assign d_pmem_rdata = line;
    assign d_pmem_resp  = (state == DONE) && (owner == REQ_D);
    assign i_pmem_resp  = (state == DONE) && (owner == REQ_I);

`ifdef PMEM_PREFETCH_EN
    assign pf_ready  = (state == DONE) && (owner == REQ_PF);
    assign unused_ok = ^{i_pmem_address[4:0], d_pmem_address[4:0], pf_address[4:0]};
`else
    assign pf_ready  = 1'b0;
    assign unused_ok = ^{i_pmem_address[4:0], d_pmem_address[4:0], pf_req, pf_address};
`endif

    // The dcache must never ask for a read and a writeback at once.
    assert property (@(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_pmem_read = 1'b0;
    logic [31:0]  i_pmem_address = '0;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         pf_req = 1'b0;
    logic [31:0]  pf_address = '0;
    logic         pf_ready;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [31:0]  d_pmem_address = '0;
    logic [255:0] d_pmem_wdata = '0;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .pf_req         (pf_req),
        .pf_address     (pf_address),
        .pf_ready       (pf_ready),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

`ifdef PMEM_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    int err_count   = 0;
    int check_count = 0;

    // Reference model: what each client has outstanding, and what line the
    // caches should currently be seeing.
    int           pend_d = 0;     // 0 none, 1 read, 2 write
    bit           pend_i = 1'b0;
    bit           pend_pf = 1'b0;
    logic [31:0]  addr_d, addr_i, addr_pf;
    logic [255:0] wdata_d = '0;
    logic [255:0] exp_line = '0;
    logic [63:0]  beat_src [4];

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic raiseD(input bit wr);
        addr_d = $urandom;
        d_pmem_address = addr_d;
        if (wr) begin
            for (int j = 0; j < 8; j++) wdata_d[32*j +: 32] = $urandom;
            d_pmem_wdata = wdata_d;
            d_pmem_write = 1'b1;
            pend_d = 2;
        end else begin
            d_pmem_read = 1'b1;
            pend_d = 1;
        end
    endtask

    task automatic raiseI(input logic [31:0] a);
        addr_i = a;
        i_pmem_address = a;
        i_pmem_read = 1'b1;
        pend_i = 1'b1;
    endtask

    task automatic raisePf(input logic [31:0] a);
        addr_pf = a;
        pf_address = a;
        pf_req = 1'b1;
        pend_pf = 1'b1;
    endtask

    // Fixed priority: dcache, then icache demand, then prefetch (if built in).
    function automatic int pickWinner();
        if (pend_d != 0) return 1;
        if (pend_i) return 2;
        if (PF_EN && pend_pf) return 3;
        return 0;
    endfunction

    task automatic maybeRaise();
        int r;
        if ($urandom_range(0, 3) != 0) return;
        r = $urandom_range(0, 2);
        if (r == 0 && pend_d == 0) raiseD($urandom_range(0, 1) == 1);
        else if (r == 1 && !pend_i) raiseI($urandom);
        else if (r == 2 && !pend_pf) raisePf($urandom);
    endtask

    // Called at a negedge where the DUT is IDLE with requests presented.
    // Plays the memory side for one burst and checks the outcome.
    // abort_at < 4 pulls reset just before that beat would be returned.
    task automatic applyStimulus(input int abort_at, input bit use_preset, input bit force_i);
        int w;
        bit is_wr;
        int gaps;
        logic [31:0] ea;
        w = pickWinner();
        is_wr = (w == 1) && (pend_d == 2);
        ea = ((w == 1) ? addr_d : (w == 2) ? addr_i : addr_pf) & 32'hFFFF_FFE0;
        if (!use_preset) begin
            for (int j = 0; j < 4; j++) beat_src[j] = {$urandom, $urandom};
        end
        mem_resp = 1'b0;
        @(negedge clk);
        checkOutput("grant_read",  mem_read,  !is_wr);
        checkOutput("grant_write", mem_write, is_wr);
        checkOutput("grant_addr",  mem_address, ea);
        for (int b = 0; b < 4; b++) begin
            if (b == abort_at) begin
                mem_resp = 1'b0;
                rst = 1'b0;
                #1;
                checkOutput("abort_rd",    mem_read, 1'b0);
                checkOutput("abort_wr",    mem_write, 1'b0);
                checkOutput("abort_addr",  mem_address, 32'h0);
                checkOutput("abort_wdata", mem_wdata, 64'h0);
                checkOutput("abort_iline", i_pmem_rdata, 256'h0);
                checkOutput("abort_dline", d_pmem_rdata, 256'h0);
                checkOutput("abort_resp",  {i_pmem_resp, d_pmem_resp, pf_ready}, 3'b000);
                exp_line = '0;
                i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pf_req = 1'b0;
                pend_d = 0; pend_i = 1'b0; pend_pf = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            gaps = 0;
            while (gaps < 3 && $urandom_range(0, 2) == 0) begin
                mem_resp = 1'b0;
                mem_rdata = {$urandom, $urandom};
                maybeRaise();
                @(negedge clk);
                checkOutput("burst_hold", {mem_read, mem_write}, {!is_wr, is_wr});
                gaps++;
            end
            if (force_i && b == 2 && !pend_i) raiseI($urandom);
            mem_resp = 1'b1;
            mem_rdata = beat_src[b];
            if (is_wr) checkOutput($sformatf("wbeat%0d", b), mem_wdata, wdata_d[64*b +: 64]);
            @(negedge clk);
        end
        // DONE cycle: a stray mem_resp here must be ignored.
        mem_resp = 1'b0;
        if ($urandom_range(0, 1) == 1) mem_resp = 1'b1;
        mem_rdata = {$urandom, $urandom};
        if (!is_wr) exp_line = {beat_src[3], beat_src[2], beat_src[1], beat_src[0]};
        checkOutput("done_dresp",  d_pmem_resp, w == 1);
        checkOutput("done_iresp",  i_pmem_resp, w == 2);
        checkOutput("done_pfrdy",  pf_ready,    w == 3);
        checkOutput("done_memop",  {mem_read, mem_write}, 2'b00);
        checkOutput("done_iline",  i_pmem_rdata, exp_line);
        checkOutput("done_dline",  d_pmem_rdata, exp_line);
        case (w)
            1: begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; pend_d = 0; end
            2: begin i_pmem_read = 1'b0; pend_i = 1'b0; end
            3: begin pf_req = 1'b0; pend_pf = 1'b0; end
            default: ;
        endcase
        @(negedge clk);
        mem_resp = 1'b0;
        checkOutput("idle_resp",  {i_pmem_resp, d_pmem_resp, pf_ready}, 3'b000);
        checkOutput("idle_memop", {mem_read, mem_write}, 2'b00);
        checkOutput("idle_wdata", mem_wdata, 64'h0);
        checkOutput("idle_line",  i_pmem_rdata, exp_line);
    endtask

    task automatic drainAll();
        while (pickWinner() != 0) applyStimulus(4, 1'b0, 1'b0);
    endtask

    task automatic idleGlitch();
        mem_resp = 1'b1;
        mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_resp = 1'b0;
        checkOutput("glitch_memop", {mem_read, mem_write}, 2'b00);
        checkOutput("glitch_resp",  {i_pmem_resp, d_pmem_resp, pf_ready}, 3'b000);
        checkOutput("glitch_line",  d_pmem_rdata, exp_line);
        @(negedge clk);
        checkOutput("glitch_after", {mem_read, mem_write}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_memop", {mem_read, mem_write}, 2'b00);
        checkOutput("rst_addr",  mem_address, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 64'h0);
        checkOutput("rst_iline", i_pmem_rdata, 256'h0);
        checkOutput("rst_dline", d_pmem_rdata, 256'h0);
        checkOutput("rst_resp",  {i_pmem_resp, d_pmem_resp, pf_ready}, 3'b000);
        rst = 1'b1;
        @(negedge clk);

        // Demand read of a known line at an unaligned address.
        beat_src[0] = 64'h1111_1111_1111_1111;
        beat_src[1] = 64'h2222_2222_2222_2222;
        beat_src[2] = 64'h3333_3333_3333_3333;
        beat_src[3] = 64'h4444_4444_4444_4444;
        raiseI(32'h0000_1234);
        applyStimulus(4, 1'b1, 1'b0);
        checkOutput("directed_line", i_pmem_rdata,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Writeback and demand read in the same cycle: write goes first.
        raiseD(1'b1);
        raiseI($urandom);
        drainAll();

        idleGlitch();

`ifdef PMEM_PREFETCH_EN
        // Prefetch with a demand read arriving mid-burst.
        raisePf(32'h0000_0040);
        applyStimulus(4, 1'b0, 1'b1);
        drainAll();
`else
        // Prefetch port is ignored entirely.
        raisePf(32'h0000_0040);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checkOutput("pf_ignored", {mem_read, mem_write, pf_ready}, 3'b000);
        end
`endif

        // Reset after two beats of a read, then a clean read afterwards.
        raiseI($urandom);
        applyStimulus(2, 1'b0, 1'b0);
        raiseI($urandom);
        applyStimulus(4, 1'b0, 1'b0);
        drainAll();

        // Randomized rounds of overlapping requests.
        for (int r = 0; r < 40; r++) begin
            maybeRaise();
            if (pend_d == 0 && $urandom_range(0, 1) == 1) raiseD($urandom_range(0, 1) == 1);
            if (!pend_i && $urandom_range(0, 1) == 1) raiseI($urandom);
            if (!pend_pf && $urandom_range(0, 2) == 0) raisePf($urandom);
            drainAll();
            if ($urandom_range(0, 3) == 0) idleGlitch();
        end

        pf_req = 1'b0;
        pend_pf = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
